fcvt_int_s: RTL and testbench

- Parametrised, elastic FP32-to-integer converter for the Float pipeline.
- Implements RISC-V fcvt.w.s / fcvt.wu.s, and fcvt.l.s / fcvt.lu.s when OUT_W=64.
- Supports all five rounding modes, signed/unsigned select per operation, and IEEE exception flags.
- Uses a 3-stage valid/ready pipeline with per-stage bubble collapsing, a sideband tag and a flush input; sits between FP issue and writeback.

---
 rtl/fcvt_int_s.sv | 183 ++++++++++++++++++
 tb/tb_fcvt_int_s.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fcvt_int_s.sv
// rtl/fcvt_int_s.sv - FP32 to signed/unsigned integer converter, 3-stage elastic pipeline
module fcvt_int_s #(
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic             in_unsigned,
  input  logic [2:0]       in_rm,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_result,
  output logic [4:0]       out_fflags,
  output logic [TAG_W-1:0] out_tag
);
  localparam int MW = OUT_W + 1;
  localparam logic signed [9:0] OVF_E   = 10'(MW);
  localparam logic [MW-1:0]     POS_LIM = {2'b00, {(OUT_W-1){1'b1}}};
  localparam logic [MW-1:0]     NEG_LIM = {2'b01, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0]  MAX_S   = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0]  MIN_S   = {1'b1, {(OUT_W-1){1'b0}}};

  logic s1_valid, s2_valid;
  logic s1_en, s2_en, s3_en;

  // Each stage loads when empty or when its current content moves on.
  assign s3_en    = !out_valid || out_ready;
  assign s2_en    = !s2_valid || s3_en;
  assign s1_en    = !s1_valid || s2_en;
  assign in_ready = s1_en;

  logic                    s1_sign, s1_nan, s1_inf, s1_uns;
  logic [2:0]              s1_rm;
  logic [TAG_W-1:0]        s1_tag;
  logic [23:0]             s1_m;
  logic signed [9:0]       s1_exp;
  logic                    in_e_max, in_e_zero;
  logic signed [9:0]       exp_c;

  assign in_e_max  = &in_a[30:23];
  assign in_e_zero = ~|in_a[30:23];
  assign exp_c     = in_e_zero ? -10'sd126 : $signed({2'b00, in_a[30:23]}) - 10'sd127;

  logic [4:0]    rsh_amt;
  logic [5:0]    lsh_amt;
  logic [47:0]   rsh;
  logic [MW-1:0] m_ext, lsh, mag_c;
  logic          g_c, st_c, ovf_c;

  assign rsh_amt = 5'(10'sd23 - s1_exp);
  assign lsh_amt = 6'(s1_exp - 10'sd23);
  assign rsh     = {s1_m, 24'd0} >> rsh_amt;
  assign m_ext   = {{(MW-24){1'b0}}, s1_m};
  assign lsh     = m_ext << lsh_amt;

  // E = -1 still fits the right-shift window; anything smaller is pure sticky.
  always_comb begin
    mag_c = '0;
    g_c   = 1'b0;
    st_c  = 1'b0;
    ovf_c = 1'b0;
    if (s1_exp >= OVF_E) begin
      ovf_c = 1'b1;
    end else if (s1_exp >= 10'sd23) begin
      mag_c = lsh;
    end else if (s1_exp >= -10'sd1) begin
      mag_c = {{(MW-24){1'b0}}, rsh[47:24]};
      g_c   = rsh[23];
      st_c  = |rsh[22:0];
    end else begin
      st_c  = |s1_m;
    end
  end

  logic                s2_sign, s2_nan, s2_inf, s2_ovf, s2_uns, s2_g, s2_st;
  logic [2:0]          s2_rm;
  logic [TAG_W-1:0]    s2_tag;
  logic [MW-1:0]       s2_mag;
  logic                inc, nv_c, nx_c;
  logic [MW-1:0]       r_c;
  logic [OUT_W-1:0]    res_c;

  always_comb begin
    case (s2_rm)
      3'b000:  inc = s2_g & (s2_st | s2_mag[0]);
      3'b010:  inc = s2_sign & (s2_g | s2_st);
      3'b011:  inc = !s2_sign & (s2_g | s2_st);
      3'b100:  inc = s2_g;
      default: inc = 1'b0;
    endcase
  end

  assign r_c = s2_mag + {{(MW-1){1'b0}}, inc};

  always_comb begin
    res_c = '0;
    nv_c  = 1'b0;
    if (s2_nan) begin
      nv_c  = 1'b1;
      res_c = s2_uns ? '1 : MAX_S;
    end else if (s2_inf || s2_ovf) begin
      nv_c = 1'b1;
      if (!s2_sign) res_c = s2_uns ? '1 : MAX_S;
      else          res_c = s2_uns ? '0 : MIN_S;
    end else if (s2_uns) begin
      if (s2_sign) begin
        nv_c = |r_c;
      end else if (r_c[OUT_W]) begin
        nv_c  = 1'b1;
        res_c = '1;
      end else begin
        res_c = r_c[OUT_W-1:0];
      end
    end else if (!s2_sign) begin
      if (r_c > POS_LIM) begin
        nv_c  = 1'b1;
        res_c = MAX_S;
      end else begin
        res_c = r_c[OUT_W-1:0];
      end
    end else begin
      if (r_c > NEG_LIM) begin
        nv_c  = 1'b1;
        res_c = MIN_S;
      end else begin
        res_c = -r_c[OUT_W-1:0];
      end
    end
  end

  assign nx_c = (s2_g | s2_st) & !nv_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s2_valid   <= 1'b0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_fflags <= '0;
      out_tag    <= '0;
    end else if (flush) begin
      s1_valid   <= 1'b0;
      s2_valid   <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      if (s1_en) s1_valid  <= in_valid;
      if (s2_en) s2_valid  <= s1_valid;
      if (s3_en) out_valid <= s2_valid;
      if (s1_en && in_valid) begin
        s1_sign <= in_a[31];
        s1_nan  <= in_e_max && (|in_a[22:0]);
        s1_inf  <= in_e_max && !(|in_a[22:0]);
        s1_m    <= {!in_e_zero, in_a[22:0]};
        s1_exp  <= exp_c;
        s1_uns  <= in_unsigned;
        s1_rm   <= in_rm;
        s1_tag  <= in_tag;
      end
      if (s2_en && s1_valid) begin
        s2_sign <= s1_sign;
        s2_nan  <= s1_nan;
        s2_inf  <= s1_inf;
        s2_ovf  <= ovf_c;
        s2_mag  <= mag_c;
        s2_g    <= g_c;
        s2_st   <= st_c;
        s2_uns  <= s1_uns;
        s2_rm   <= s1_rm;
        s2_tag  <= s1_tag;
      end
      if (s3_en && s2_valid) begin
        out_result <= res_c;
        out_fflags <= {nv_c, 3'b000, nx_c};
        out_tag    <= s2_tag;
      end
    end
  end
endmodule

// File: tb/tb_fcvt_int_s.sv
// tb/tb_fcvt_int_s.sv - scoreboard bench for fcvt_int_s at OUT_W=32 and OUT_W=64
module tb_fcvt_int_s;
  typedef struct packed {
    logic [4:0]  tag;
    logic [31:0] r32;
    logic [4:0]  f32;
    logic [63:0] r64;
    logic [4:0]  f64;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_unsigned, out_ready;
  logic [31:0] in_a;
  logic [2:0]  in_rm;
  logic [4:0]  in_tag;
  logic        rdy32, rdy64, ov32, ov64;
  logic [31:0] res32;
  logic [63:0] res64;
  logic [4:0]  ff32, ff64, tag32, tag64;
  logic [4:0]  tag_q = 5'd0;
  logic [31:0] ints [10];
  exp_t        sb[$];
  int          out_cyc[$];
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  bit          tog_on = 1'b0;

  fcvt_int_s #(.OUT_W(32), .TAG_W(5)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .in_a(in_a), .in_unsigned(in_unsigned), .in_rm(in_rm), .in_tag(in_tag),
    .out_valid(ov32), .out_ready(out_ready), .out_result(res32),
    .out_fflags(ff32), .out_tag(tag32)
  );

  fcvt_int_s #(.OUT_W(64), .TAG_W(5)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .in_a(in_a), .in_unsigned(in_unsigned), .in_rm(in_rm), .in_tag(in_tag),
    .out_valid(ov64), .out_ready(out_ready), .out_result(res64),
    .out_fflags(ff64), .out_tag(tag64)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] r32, input logic [4:0] f32,
                          input logic [63:0] r64, input logic [4:0] f64);
    exp_t e;
    e.tag = tag_q;
    e.r32 = r32;
    e.f32 = f32;
    e.r64 = r64;
    e.f64 = f64;
    sb.push_back(e);
    tag_q = tag_q + 5'd1;
  endtask

  task automatic send(input logic [31:0] a, input logic u, input logic [2:0] rm,
                      input logic [31:0] r32, input logic [4:0] f32,
                      input logic [63:0] r64, input logic [4:0] f64);
    bit done;
    int n;
    done = 1'b0;
    n = 0;
    in_valid = 1'b1; in_a = a; in_unsigned = u; in_rm = rm; in_tag = tag_q;
    while (!done && n < 40) begin
      @(negedge clk);
      if (rdy32) begin
        push_exp(r32, f32, r64, f64);
        done = 1'b1;
      end
      step();
      n++;
    end
    vectors++;
    assert (done) else begin
      miscompares++;
      $error("FAIL send_timeout observed=in_ready_low expected=accept a=%h", a);
    end
  endtask

  task automatic send_int(input int k);
    send(ints[k-1], 1'b0, 3'd1, 32'(k), 5'd0, 64'(k), 5'd0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    while (sb.size() != 0 && n < 60) begin
      step();
      n++;
    end
    chk("drain_left", 64'(sb.size()), 64'd0);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && ov32 && out_ready) begin
      out_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        vectors++;
        assert (sb.size() != 0) else begin
          miscompares++;
          $error("FAIL spurious_out observed=tag%0d expected=none", tag32);
        end
      end else begin
        e = sb.pop_front();
        chk("tag32", 64'(tag32), 64'(e.tag));
        chk("res32", 64'(res32), 64'(e.r32));
        chk("ff32", 64'(ff32), 64'(e.f32));
        chk("ov64", 64'(ov64), 64'd1);
        chk("tag64", 64'(tag64), 64'(e.tag));
        chk("res64", res64, e.r64);
        chk("ff64", 64'(ff64), 64'(e.f64));
      end
    end
  end

  initial begin
    int i0;
    ints = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
             32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000, 32'h41200000};
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_a = '0; in_unsigned = 1'b0;
    in_rm = 3'd0; in_tag = '0; out_ready = 1'b0;
    step(); step();
    chk("rst_ov", 64'(ov32), 64'd0);
    chk("rst_res", 64'(res32), 64'd0);
    chk("rst_ff", 64'(ff32), 64'd0);
    chk("rst_tag", 64'(tag32), 64'd0);
    chk("rst_rdy", 64'(rdy32), 64'd1);
    rst = 1'b0;
    out_ready = 1'b1;

    // Directed values, back to back.
    send(32'h40490FDB, 0, 3'd0, 32'd3, 5'h01, 64'd3, 5'h01);
    send(32'h3F800000, 0, 3'd1, 32'd1, 5'h00, 64'd1, 5'h00);
    send(32'h40200000, 0, 3'd0, 32'd2, 5'h01, 64'd2, 5'h01);
    send(32'h40200000, 0, 3'd1, 32'd2, 5'h01, 64'd2, 5'h01);
    send(32'h40200000, 0, 3'd2, 32'd2, 5'h01, 64'd2, 5'h01);
    send(32'h40200000, 0, 3'd3, 32'd3, 5'h01, 64'd3, 5'h01);
    send(32'h40200000, 0, 3'd4, 32'd3, 5'h01, 64'd3, 5'h01);
    send(32'h40200000, 0, 3'd5, 32'd2, 5'h01, 64'd2, 5'h01);
    send(32'hC0200000, 0, 3'd2, 32'hFFFFFFFD, 5'h01, 64'hFFFFFFFFFFFFFFFD, 5'h01);
    send(32'hC0200000, 0, 3'd3, 32'hFFFFFFFE, 5'h01, 64'hFFFFFFFFFFFFFFFE, 5'h01);
    send(32'hC0200000, 0, 3'd0, 32'hFFFFFFFE, 5'h01, 64'hFFFFFFFFFFFFFFFE, 5'h01);
    send(32'h00000001, 0, 3'd3, 32'd1, 5'h01, 64'd1, 5'h01);
    send(32'h7FC00000, 0, 3'd0, 32'h7FFFFFFF, 5'h10, 64'h7FFFFFFFFFFFFFFF, 5'h10);
    send(32'h7FC00000, 1, 3'd0, 32'hFFFFFFFF, 5'h10, 64'hFFFFFFFFFFFFFFFF, 5'h10);
    send(32'hFF800000, 0, 3'd0, 32'h80000000, 5'h10, 64'h8000000000000000, 5'h10);
    send(32'hFF800000, 1, 3'd0, 32'h0, 5'h10, 64'h0, 5'h10);
    send(32'h7F800000, 1, 3'd0, 32'hFFFFFFFF, 5'h10, 64'hFFFFFFFFFFFFFFFF, 5'h10);
    send(32'h4F000000, 0, 3'd0, 32'h7FFFFFFF, 5'h10, 64'h0000000080000000, 5'h00);
    send(32'h4F000000, 1, 3'd0, 32'h80000000, 5'h00, 64'h0000000080000000, 5'h00);
    send(32'hCF000000, 0, 3'd0, 32'h80000000, 5'h00, 64'hFFFFFFFF80000000, 5'h00);
    send(32'hBF000000, 1, 3'd1, 32'h0, 5'h01, 64'h0, 5'h01);
    send(32'hBF800000, 1, 3'd1, 32'h0, 5'h10, 64'h0, 5'h10);
    send(32'h5F000000, 0, 3'd0, 32'h7FFFFFFF, 5'h10, 64'h7FFFFFFFFFFFFFFF, 5'h10);
    send(32'h5F000000, 1, 3'd0, 32'hFFFFFFFF, 5'h10, 64'h8000000000000000, 5'h00);
    send(32'h00000000, 0, 3'd0, 32'h0, 5'h00, 64'h0, 5'h00);
    send(32'h80000000, 0, 3'd3, 32'h0, 5'h00, 64'h0, 5'h00);
    send(32'hBE99999A, 0, 3'd1, 32'h0, 5'h01, 64'h0, 5'h01);
    drain();

    // Backpressure: three held, fourth refused, then release.
    out_ready = 1'b0;
    send_int(1); send_int(2); send_int(3);
    in_valid = 1'b1; in_a = ints[3];
    @(negedge clk);
    chk("bp_in_ready", 64'(rdy32), 64'd0);
    chk("bp_ov", 64'(ov32), 64'd1);
    chk("bp_tag_head", 64'(tag32), 64'(sb[0].tag));
    step(); step();
    chk("bp_tag_hold", 64'(tag32), 64'(sb[0].tag));
    chk("bp_res_hold", 64'(res32), 64'd1);
    out_ready = 1'b1;
    send_int(4); send_int(5);
    drain();

    // Alternating out_ready halves throughput.
    i0 = out_cyc.size();
    tog_on = 1'b1;
    fork
      begin
        while (tog_on) begin
          step();
          out_ready = ~out_ready;
        end
      end
    join_none
    for (int k = 1; k <= 10; k++) send_int(k);
    drain();
    tog_on = 1'b0;
    step(); step();
    out_ready = 1'b1;
    chk("toggle_span", 64'(out_cyc[i0+9] - out_cyc[i0]), 64'd18);

    // Flush with three in flight, then measure latency of the next op.
    out_ready = 1'b0;
    send_int(1); send_int(2); send_int(3);
    flush = 1'b1; in_valid = 1'b1; in_a = ints[3];
    sb.delete();
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_ov32", 64'(ov32), 64'd0);
    chk("flush_ov64", 64'(ov64), 64'd0);
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = ints[6]; in_unsigned = 1'b0; in_rm = 3'd1; in_tag = tag_q;
    push_exp(32'd7, 5'd0, 64'd7, 5'd0);
    step();
    in_valid = 1'b0;
    chk("lat_e1", 64'(ov32), 64'd0);
    step();
    chk("lat_e2", 64'(ov32), 64'd0);
    step();
    chk("lat_e3", 64'(ov32), 64'd1);
    drain();

    // Reset in the middle of traffic.
    out_ready = 1'b0;
    send_int(4); send_int(5);
    step();
    rst = 1'b1; in_valid = 1'b1; in_a = ints[5];
    sb.delete();
    step();
    chk("mrst_ov", 64'(ov32), 64'd0);
    chk("mrst_res32", 64'(res32), 64'd0);
    chk("mrst_res64", res64, 64'd0);
    chk("mrst_ff", 64'(ff32), 64'd0);
    chk("mrst_tag", 64'(tag32), 64'd0);
    chk("mrst_rdy", 64'(rdy32), 64'd1);
    rst = 1'b0; in_valid = 1'b0;
    out_ready = 1'b1;
    send_int(9);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
